// File: rtl/c3lib_pipe_reset_vld_if.sv
`default_nettype none
// ===========================================================================
// c3lib_pipe_reset_vld_if : handshake/data bundle for the reset-valid pipe
// Rev 1.0
// ===========================================================================
interface c3lib_pipe_reset_vld_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
);
   logic             ce;
   logic             clr;
   logic             vld_in;
   logic [WIDTH-1:0] data_in;
   logic             vld_out;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    occ_cnt;

   modport master (
      output ce, clr, vld_in, data_in,
      input  vld_out, data_out, occ_cnt
   );

   modport slave (
      input  ce, clr, vld_in, data_in,
      output vld_out, data_out, occ_cnt
   );
endinterface
`default_nettype wire

// File: rtl/c3lib_pipe_reset_vld.sv
`default_nettype none
// ===========================================================================
// c3lib_pipe_reset_vld : stallable, flushable reset-value pipeline with valids
// Rev 1.0
// ===========================================================================
module c3lib_pipe_reset_vld #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
   parameter bit               DATA_GATE = 1'b0,
   parameter int               CW        = $clog2(DEPTH + 1)
) (
   input wire logic                clk,
   input wire logic                rst,
   c3lib_pipe_reset_vld_if.slave   bus
);
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];
   logic [CW-1:0]    cnt;

   logic [DEPTH-1:0] src_vld;
   logic [WIDTH-1:0] src_dat [DEPTH];

   genvar i;
   for (i = 0; i < DEPTH; i++) begin : g_src
      if (i == 0) begin : g_head
         assign src_vld[i] = bus.vld_in;
         assign src_dat[i] = bus.data_in;
      end else begin : g_body
         assign src_vld[i] = vld[i-1];
         assign src_dat[i] = dat[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         cnt <= '0;
         for (int k = 0; k < DEPTH; k++) dat[k] <= RST_VAL;
      end else if (bus.clr) begin
         vld <= '0;
         cnt <= '0;
         for (int k = 0; k < DEPTH; k++) dat[k] <= RST_VAL;
      end else if (bus.ce) begin
         for (int k = 0; k < DEPTH; k++) begin
            vld[k] <= src_vld[k];
            // With gating, a stage's data only moves behind a valid item.
            if (!DATA_GATE || src_vld[k]) dat[k] <= src_dat[k];
         end
         // Modulo-CW arithmetic is exact: the count never leaves 0..DEPTH.
         cnt <= cnt + CW'(bus.vld_in) - CW'(vld[DEPTH-1]);
      end
   end

   assign bus.vld_out  = vld[DEPTH-1];
   assign bus.data_out = dat[DEPTH-1];
   assign bus.occ_cnt  = cnt;
endmodule
`default_nettype wire
